// File: rtl/rsa_pkg.sv
// Shared RSA project definitions: the Montgomery iteration FSM state encoding.
package rsa_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_CORR = 2'd2,
      S_DONE = 2'd3
   } mont_state_t;

endpackage : rsa_pkg

// File: rtl/mont_step.sv
// One radix-2 Montgomery step: pick q so the sum is even, add A[i]*B and q*M, halve.
module mont_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH+1:0] i_acc,
   input  logic             i_a_bit,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_m,
   output logic [WIDTH+1:0] o_acc_next
);

   logic             w_q;
   logic [WIDTH+1:0] w_b_term;
   logic [WIDTH+1:0] w_m_term;
   logic [WIDTH+1:0] w_sum;

   // acc < 2M and B, M < 2^WIDTH keep the sum below 2^(WIDTH+2)
   assign w_q        = i_acc[0] ^ (i_a_bit & i_b[0]);
   assign w_b_term   = i_a_bit ? {2'b00, i_b} : '0;
   assign w_m_term   = w_q ? {2'b00, i_m} : '0;
   assign w_sum      = i_acc + w_b_term + w_m_term;
   assign o_acc_next = w_sum >> 1;

endmodule : mont_step

// File: rtl/mont_iter.sv
// Iterative Montgomery multiplier: R = A*B*2^-WIDTH mod M, one operand bit per enabled cycle.
module mont_iter
   import rsa_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] M,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output mont_state_t      o_dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   mont_state_t      r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH+1:0] r_acc;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_res;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH+1:0] w_acc_next;
   logic             w_acc_ge_m;
   logic [WIDTH-1:0] w_acc_sub;

   mont_step #(.WIDTH(WIDTH)) u_step (
      .i_acc      (r_acc),
      .i_a_bit    (r_a[r_cnt]),
      .i_b        (r_b),
      .i_m        (r_m),
      .o_acc_next (w_acc_next)
   );

   // Final acc is below 2M, so the difference fits in WIDTH bits when taken
   assign w_acc_ge_m = (r_acc >= {2'b00, r_m});
   assign w_acc_sub  = r_acc[WIDTH-1:0] - r_m;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_m     <= '0;
         r_res   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (ena) begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_m     <= M;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_state <= S_CORR;
               end
            end
            S_CORR: begin
               r_res   <= w_acc_ge_m ? w_acc_sub : r_acc[WIDTH-1:0];
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // A stalled DONE cycle shows no pulse; it appears once ena returns
   assign done        = r_done & ena;
   assign R           = r_res;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule : mont_iter

// File: tb/tb_mont_iter.sv
// Directed bench for mont_iter (WIDTH=4) with hand-computed Montgomery results.
module tb_mont_iter;
   import rsa_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         ena;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] m;
   logic [W-1:0] r;
   logic         busy;
   logic         done;
   mont_state_t  dbg_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mont_iter #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .start       (start),
      .A           (a),
      .B           (b),
      .M           (m),
      .R           (r),
      .busy        (busy),
      .done        (done),
      .o_dbg_state (dbg_state)
   );

   // Returns at the falling edge of the first cycle after the start edge
   task automatic do_start(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] im);
      @(negedge clk);
      a = ia;
      b = ib;
      m = im;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ena = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      m = '0;
      repeat (3) @(negedge clk);
      total++;
      if (r !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== S_IDLE) begin
         bad++;
         $display("FAIL reset: R=%0d busy=%b done=%b state=%0d, want R=0 busy=0 done=0 state=IDLE",
                  r, busy, done, dbg_state);
      end
      rst = 1'b0;
      ena = 1'b1;
   endtask

   task automatic test_basic();
      logic [W-1:0] tv_a [6] = '{4'd7, 4'd11, 4'd1, 4'd0, 4'd3, 4'd14};
      logic [W-1:0] tv_b [6] = '{4'd5, 4'd12, 4'd1, 4'd9, 4'd4, 4'd14};
      logic [W-1:0] tv_m [6] = '{4'd13, 4'd13, 4'd13, 4'd13, 4'd11, 4'd15};
      logic [W-1:0] tv_r [6] = '{4'd3, 4'd5, 4'd9, 4'd0, 4'd9, 4'd1};
      int cyc;
      for (int k = 0; k < 6; k++) begin
         do_start(tv_a[k], tv_b[k], tv_m[k]);
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy[%0d]: busy=%b want 1", k, busy);
         end
         wait_done(cyc);
         total++;
         if (cyc !== 6) begin
            bad++;
            $display("FAIL basic_latency[%0d]: cycles=%0d want 6", k, cyc);
         end
         total++;
         if (r !== tv_r[k] || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_result[%0d]: R=%0d busy=%b want R=%0d busy=0", k, r, busy, tv_r[k]);
         end
         @(negedge clk);
         total++;
         if (done !== 1'b0 || dbg_state !== S_IDLE || r !== tv_r[k]) begin
            bad++;
            $display("FAIL basic_after[%0d]: done=%b state=%0d R=%0d want done=0 IDLE R=%0d",
                     k, done, dbg_state, r, tv_r[k]);
         end
      end
   endtask

   task automatic test_ena_stall();
      int first = 0;
      int pulses = 0;
      int stall_bad = 0;
      do_start(4'd7, 4'd5, 4'd13);
      for (int c = 2; c <= 14; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            if (first == 0) first = c;
         end
         if (c >= 2 && c <= 5 && (busy !== 1'b1 || r !== 4'd1)) stall_bad++;
         if ((c == 3 || c == 4) && done !== 1'b0) stall_bad++;
         if (c == 2) begin
            ena = 1'b0;
            start = 1'b1;
            a = 4'd15;
            b = 4'd15;
         end
         if (c == 5) ena = 1'b1;
         if (c == 6) start = 1'b0;
      end
      total++;
      if (stall_bad != 0) begin
         bad++;
         $display("FAIL stall_hold: %0d bad samples of busy/R/done, want busy=1 R=1 done=0", stall_bad);
      end
      total++;
      if (first !== 9 || pulses !== 1) begin
         bad++;
         $display("FAIL stall_done: first=%0d pulses=%0d want first=9 pulses=1", first, pulses);
      end
      total++;
      if (r !== 4'd3) begin
         bad++;
         $display("FAIL stall_result: R=%0d want 3", r);
      end
   endtask

   task automatic test_reset_abort();
      int pulses = 0;
      int cyc;
      do_start(4'd7, 4'd5, 4'd13);
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || r !== 4'd0 || done !== 1'b0 || dbg_state !== S_IDLE) begin
         bad++;
         $display("FAIL abort_state: busy=%b R=%0d done=%b state=%0d want 0/0/0/IDLE",
                  busy, r, done, dbg_state);
      end
      rst = 1'b0;
      start = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL abort_quiet: done/busy seen %0d times want 0", pulses);
      end
      do_start(4'd11, 4'd12, 4'd13);
      wait_done(cyc);
      total++;
      if (cyc !== 6 || r !== 4'd5) begin
         bad++;
         $display("FAIL abort_restart: cycles=%0d R=%0d want cycles=6 R=5", cyc, r);
      end
   endtask

   task automatic test_back_to_back();
      int d [2] = '{0, 0};
      logic [W-1:0] rr [2] = '{4'd15, 4'd15};
      int n = 0;
      @(negedge clk);
      a = 4'd1;
      b = 4'd1;
      m = 4'd13;
      start = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (n < 2) begin
               d[n] = c;
               rr[n] = r;
            end
            n++;
            a = 4'd0;
            b = 4'd9;
            if (n >= 2) start = 1'b0;
         end
      end
      start = 1'b0;
      total++;
      if (n !== 2 || d[0] !== 6 || d[1] !== 13) begin
         bad++;
         $display("FAIL b2b_timing: pulses=%0d at %0d,%0d want 2 at 6,13", n, d[0], d[1]);
      end
      total++;
      if (rr[0] !== 4'd9 || rr[1] !== 4'd0) begin
         bad++;
         $display("FAIL b2b_result: R=%0d,%0d want 9,0", rr[0], rr[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ena_stall();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mont_iter
